// File: rtl/writeback_stage.sv
// Writeback stage: one pipeline register feeding the register-file write port, load extraction, retire counter.
// Latency: 1 cycle from acceptance to register-file write; outputs are combinational from the register.
// Backpressure: in_ready = !hold; hold freezes the register and suppresses the write until released.
module writeback_stage #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic             hold,
    input  logic [31:0]      alu_result,
    input  logic [31:0]      load_data,
    input  logic [31:0]      pc_plus4,
    input  logic [4:0]       rd_in,
    input  logic             reg_write_in,
    input  logic [1:0]       wb_sel,
    input  logic [2:0]       funct3,
    output logic             RegWrite,
    output logic [4:0]       rd,
    output logic [31:0]      write_data,
    output logic             load_fault,
    output logic [CNT_W-1:0] retired
);

    typedef struct packed {
        logic        vld;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        reg_write;
        logic [1:0]  wb_sel;
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
    } wb_reg_t;

    wb_reg_t wb_q;
    logic    retire_now;
    logic    misalign;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    assign in_ready = !hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q <= '0;
        end else if (flush) begin
            wb_q.vld <= 1'b0;
        end else if (!hold) begin
            wb_q.vld       <= in_valid;
            wb_q.alu       <= alu_result;
            wb_q.ld        <= load_data;
            wb_q.pc4       <= pc_plus4;
            wb_q.rd        <= rd_in;
            wb_q.reg_write <= reg_write_in;
            wb_q.wb_sel    <= wb_sel;
            wb_q.funct3    <= funct3;
            wb_q.addr_lo   <= alu_result[1:0];
        end
    end

    always_comb begin
        byte_sel = wb_q.ld[7:0];
        case (wb_q.addr_lo)
            2'b01:   byte_sel = wb_q.ld[15:8];
            2'b10:   byte_sel = wb_q.ld[23:16];
            2'b11:   byte_sel = wb_q.ld[31:24];
            default: byte_sel = wb_q.ld[7:0];
        endcase
        half_sel = wb_q.addr_lo[1] ? wb_q.ld[31:16] : wb_q.ld[15:0];

        // Illegal widths fall through to the raw word; the write is suppressed by load_fault anyway.
        case (wb_q.funct3)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_val = {24'h0, byte_sel};
            3'b101:  load_val = {16'h0, half_sel};
            default: load_val = wb_q.ld;
        endcase

        case (wb_q.wb_sel)
            2'b01:   write_data = load_val;
            2'b10:   write_data = wb_q.pc4;
            default: write_data = wb_q.alu;
        endcase

        case (wb_q.funct3)
            3'b001, 3'b101:         misalign = wb_q.addr_lo[0];
            3'b010:                 misalign = (wb_q.addr_lo != 2'b00);
            3'b011, 3'b110, 3'b111: misalign = 1'b1;
            default:                misalign = 1'b0;
        endcase
    end

    assign load_fault = wb_q.vld && !hold && (wb_q.wb_sel == 2'b01) && misalign;
    assign RegWrite   = wb_q.vld && wb_q.reg_write && (wb_q.rd != 5'd0) && !hold && !load_fault;
    assign rd         = wb_q.rd;
    assign retire_now = wb_q.vld && !hold && !load_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (retire_now) begin
            retired <= retired + CNT_W'(1);
        end
    end

endmodule
